mac_pe: RTL and testbench
=========================

Name: mac_pe

Overview:
Parametrised systolic processing element; successor to the fixed-width 8-bit MAC cell used in the matrix-multiply array.
- Forwards A/B operands to neighbour PEs with per-operand valids.
- Accumulates a tile of k_len signed or unsigned products through a 2-stage pipeline.
- Presents the result on a valid/ready drain port, so the array controller can unload results without freezing the PE.

Parameters:
A_WIDTH, 8, width of A operand
B_WIDTH, 8, width of B operand
ACC_WIDTH, 32, accumulator width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise)
CNT_WIDTH, 8, width of k_len and the internal pair counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; all flops cleared while low
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at tile start
k_len  in  CNT_WIDTH  products per tile; sampled at tile start; 0 treated as 1
a_in  in  A_WIDTH  A operand
valid_a  in  1  a_in valid
b_in  in  B_WIDTH  B operand
valid_b  in  1  b_in valid
a_out  out  A_WIDTH  registered A forward
valid_a_out  out  1  registered valid_a
b_out  out  B_WIDTH  registered B forward
valid_b_out  out  1  registered valid_b
acc_out  out  ACC_WIDTH  tile result, stable while acc_valid
acc_valid  out  1  result available
acc_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
overrun  out  1  one-cycle pulse: pair arrived while not accepting
sat_flag  out  1  sticky saturation indicator (tied 0 without feature)

Behaviour:
- Reset values: every output 0; state IDLE; accumulator, counter, product register and latched mode/length all 0.
- Forwarding (independent of state):
  - valid_a_out <= valid_a and valid_b_out <= valid_b every cycle.
  - a_out <= a_in only when valid_a; b_out <= b_in only when valid_b; otherwise hold.
  - Latency 1.
- Pair: valid_a && valid_b in the same cycle. Pairs are accepted only in IDLE or ACCUM.
- Stage 1: an accepted pair registers product p = a_in*b_in, computed signed or unsigned per the latched mode, with p_vld set.
- Stage 2: the cycle after p_vld, acc <= acc + ext(p).
  - ext sign-extends p when signed, zero-extends it when unsigned.
  - Without the feature, acc wraps modulo 2^ACC_WIDTH.
- FSM:
  - IDLE: acc held at 0. On a pair: latch signed_mode and max(k_len,1), accept the pair, cnt=1. Go to FLUSH if the latched length is 1, else ACCUM.
  - ACCUM: each pair increments cnt. When the accepted pair makes cnt equal to the latched length, go to FLUSH. Non-paired cycles: no change.
  - FLUSH: exactly 1 cycle; the final product is added. Then go to DRAIN.
  - DRAIN: acc_valid=1, acc_out=acc held stable. On acc_ready, go to IDLE with acc, cnt and sat_flag cleared and acc_valid low the next cycle.
- Latency: the final pair is accepted at edge t; acc_valid rises after edge t+2.
- Pairs arriving in FLUSH or DRAIN are dropped, with overrun=1 for that cycle. Forwarding is still performed.
- acc_ready while not in DRAIN is ignored.
- k_len and signed_mode changes mid-tile have no effect.
- Back-to-back tiles: a pair in the cycle after DRAIN exits (i.e. in IDLE) starts the next tile.
- Reset asserted mid-tile aborts immediately: partial sum discarded, all outputs 0.

Optional Feature:
MAC_PE_SAT_EN
- Defined: stage-2 addition saturates instead of wrapping.
  - Signed range: [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned range: [0, 2^ACC_WIDTH-1].
  - sat_flag sets on any clamp, stays set until DRAIN handshake or reset.
- Undefined: wrapping arithmetic; sat_flag constant 0.

Test Plan:
- Unsigned, k_len=4, pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles -> acc_valid 2 cycles after the 4th pair, acc_out=100; held until acc_ready, then busy=0.
- Signed, k_len=2, a=-3 (8'hFD), b=5, then a=-128, b=-128 -> acc_out=16369; the same bytes in unsigned mode give 1265+16384=17649.
- k_len=3 with valid_b low on alternate cycles -> only paired cycles counted; a_out/valid_a_out track a_in with 1-cycle latency throughout; result correct.
- acc_ready held low 5 cycles in DRAIN while pairs continue -> acc_out stable, overrun pulses on each pair, no accumulation; the tile after the handshake starts from 0.
- Reset pulsed low mid-ACCUM after 2 of 4 pairs -> all outputs 0 at once; the next tile result excludes the earlier pairs.
- MAC_PE_SAT_EN, ACC_WIDTH=16, unsigned, k_len=2, (255,255) twice -> acc_out=16'hFFFF, sat_flag=1; with the feature off -> acc_out=16'hFC02, sat_flag=0.

Source files
------------

// File: rtl/mac_pe.sv
// ---------------------------------------------------------------------------
// mac_pe -- systolic multiply-accumulate processing element.
//
// Forwards A/B operands (with their valids) to neighbouring PEs one cycle
// later, and accumulates a tile of k_len products through a two-stage
// pipeline: stage 1 registers the product, and stage 2 adds it into the
// accumulator. The finished tile result is unloaded on a valid/ready port.
//
// Optional feature macro: MAC_PE_SAT_EN
//   defined   -> stage-2 addition saturates, and sat_flag is a sticky clamp flag
//   undefined -> stage-2 addition wraps, and sat_flag is tied to 0
//
// Ports:
//   clk, reset        clock (rising edge); asynchronous active-low reset
//   signed_mode       1 = two's-complement operands (sampled at tile start)
//   k_len             products per tile, 0 treated as 1 (sampled at tile start)
//   a_in/valid_a      A operand and its valid
//   b_in/valid_b      B operand and its valid
//   a_out/valid_a_out registered A forward (data held when not valid)
//   b_out/valid_b_out registered B forward (data held when not valid)
//   acc_out/acc_valid tile result, stable while acc_valid is high
//   acc_ready         consumer accepts the result
//   busy              PE is inside a tile (not IDLE)
//   overrun           pulse: a pair arrived while the PE could not accept it
//   sat_flag          sticky saturation indicator
// ---------------------------------------------------------------------------
module mac_pe #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signed_mode,
    input  logic [CNT_WIDTH-1:0] k_len,
    input  logic [A_WIDTH-1:0]   a_in,
    input  logic                 valid_a,
    input  logic [B_WIDTH-1:0]   b_in,
    input  logic                 valid_b,
    output logic [A_WIDTH-1:0]   a_out,
    output logic                 valid_a_out,
    output logic [B_WIDTH-1:0]   b_out,
    output logic                 valid_b_out,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic                 sat_flag
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    if (ACC_WIDTH < P_WIDTH) begin : g_width_check
        $error("mac_pe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [P_WIDTH-1:0]     p_q, p_d;
    logic                   p_vld_q, p_vld_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   acc_valid_q, acc_valid_d;
    logic [A_WIDTH-1:0]     a_fwd_q;
    logic [B_WIDTH-1:0]     b_fwd_q;
    logic                   va_fwd_q, vb_fwd_q;

    logic                   pair, handshake, mode_eff;
    logic [CNT_WIDTH-1:0]   len_eff;
    logic signed [P_WIDTH-1:0] a_x, b_x;
    logic [P_WIDTH-1:0]     prod;
    logic [ACC_WIDTH-1:0]   p_ext, sum_wrap, sum_d;

    assign pair      = valid_a && valid_b;
    assign handshake = (state_q == DRAIN) && acc_valid_q && acc_ready;
    assign len_eff   = (k_len == '0) ? CNT_WIDTH'(1) : k_len;
    // The first pair of a tile is multiplied in the same cycle the mode is
    // latched, so it must see the live input rather than the stale register.
    assign mode_eff  = (state_q == IDLE) ? signed_mode : mode_q;

    // Extending both operands to the product width makes the low P_WIDTH bits
    // of one multiply correct for both signed and unsigned interpretations.
    assign a_x  = mode_eff ? P_WIDTH'($signed(a_in)) : P_WIDTH'(a_in);
    assign b_x  = mode_eff ? P_WIDTH'($signed(b_in)) : P_WIDTH'(b_in);
    assign prod = a_x * b_x;

    // Stage-2 adder: ext(p) follows the mode latched for the current tile.
    always_comb begin
        p_ext    = mode_q ? ACC_WIDTH'($signed(p_q)) : ACC_WIDTH'(p_q);
        sum_wrap = acc_q + p_ext;
        sum_d    = sum_wrap;
    end

`ifdef MAC_PE_SAT_EN
    logic sat_q, sat_hit;
    logic [ACC_WIDTH-1:0] sum_sat;

    always_comb begin
        sat_hit = 1'b0;
        sum_sat = sum_wrap;
        if (mode_q) begin
            // Signed overflow: operands share a sign that the result lost.
            if ((acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                (sum_wrap[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])) begin
                sat_hit = 1'b1;
                sum_sat = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum_wrap < acc_q) begin
            // Unsigned carry-out shows up as the sum wrapping below acc.
            sat_hit = 1'b1;
            sum_sat = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else if (handshake) begin
            sat_q <= 1'b0;
        end else if (p_vld_q && sat_hit) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic [ACC_WIDTH-1:0] sum_sat;
    assign sum_sat  = sum_d;
    assign sat_flag = 1'b0;
`endif

    // Next-state logic for the tile FSM and the stage-1 register.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        p_vld_d     = 1'b0;
        acc_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pair) begin
                    mode_d  = signed_mode;
                    len_d   = len_eff;
                    cnt_d   = CNT_WIDTH'(1);
                    p_d     = prod;
                    p_vld_d = 1'b1;
                    state_d = (len_eff == CNT_WIDTH'(1)) ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (pair) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    p_d     = prod;
                    p_vld_d = 1'b1;
                    if (cnt_d == len_q) state_d = FLUSH;
                end
            end
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                // acc_valid is registered, so it rises one cycle into DRAIN
                // and falls on the same edge that returns the FSM to IDLE.
                if (handshake) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (handshake) begin
            acc_d = '0;
        end else if (p_vld_q) begin
            acc_d = sum_sat;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            p_vld_q     <= p_vld_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    // Operand forwarding runs regardless of FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_fwd_q  <= '0;
            b_fwd_q  <= '0;
            va_fwd_q <= 1'b0;
            vb_fwd_q <= 1'b0;
        end else begin
            va_fwd_q <= valid_a;
            vb_fwd_q <= valid_b;
            if (valid_a) a_fwd_q <= a_in;
            if (valid_b) b_fwd_q <= b_in;
        end
    end

    assign a_out       = a_fwd_q;
    assign b_out       = b_fwd_q;
    assign valid_a_out = va_fwd_q;
    assign valid_b_out = vb_fwd_q;
    assign acc_out     = acc_q;
    assign acc_valid   = acc_valid_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = pair && ((state_q == FLUSH) || (state_q == DRAIN));

endmodule

// File: tb/tb_mac_pe.sv
// ---------------------------------------------------------------------------
// tb_mac_pe -- directed self-checking bench for mac_pe (ACC_WIDTH = 16).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, well clear of the next active edge.
// ---------------------------------------------------------------------------
module tb_mac_pe;

    localparam int AW   = 8;
    localparam int BW   = 8;
    localparam int ACCW = 16;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            signed_mode;
    logic [CW-1:0]   k_len;
    logic [AW-1:0]   a_in;
    logic            valid_a;
    logic [BW-1:0]   b_in;
    logic            valid_b;
    logic [AW-1:0]   a_out;
    logic            valid_a_out;
    logic [BW-1:0]   b_out;
    logic            valid_b_out;
    logic [ACCW-1:0] acc_out;
    logic            acc_valid;
    logic            acc_ready;
    logic            busy;
    logic            overrun;
    logic            sat_flag;

    int tests = 0;
    int fails = 0;

    mac_pe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .signed_mode(signed_mode), .k_len(k_len),
        .a_in(a_in), .valid_a(valid_a), .b_in(b_in), .valid_b(valid_b),
        .a_out(a_out), .valid_a_out(valid_a_out), .b_out(b_out),
        .valid_b_out(valid_b_out), .acc_out(acc_out), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .busy(busy), .overrun(overrun), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic va, input logic [7:0] b, input logic vb);
        a_in    = a;
        valid_a = va;
        b_in    = b;
        valid_b = vb;
    endtask

    // Waits (bounded) for acc_valid, checks the result, then handshakes.
    task automatic finish_tile(input string tag, input logic [31:0] exp);
        int n = 0;
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        while (!acc_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, " valid"}, {31'd0, acc_valid}, 32'd1);
        check({tag, " acc"}, {16'd0, acc_out}, exp);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check({tag, " idle"}, {30'd0, acc_valid, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] t3_a  [5];
        logic [7:0] t3_b  [5];
        logic       t3_vb [5];
        logic [7:0] b_hold;

        reset       = 1'b0;
        signed_mode = 1'b0;
        k_len       = '0;
        acc_ready   = 1'b0;
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("reset outputs",
              {a_out, b_out, valid_a_out, valid_b_out, acc_valid, busy, overrun, sat_flag, 2'b00},
              32'd0);
        check("reset acc", {16'd0, acc_out}, 32'd0);
        reset = 1'b1;
        tick();

        // ---- Test 1: unsigned, k_len=4, (1,2)(3,4)(5,6)(7,8) -> 100
        k_len = 8'd4;
        drive(8'd1, 1'b1, 8'd2, 1'b1); tick();
        check("t1 busy after first pair", {31'd0, busy}, 32'd1);
        drive(8'd3, 1'b1, 8'd4, 1'b1); tick();
        drive(8'd5, 1'b1, 8'd6, 1'b1); tick();
        drive(8'd7, 1'b1, 8'd8, 1'b1); tick();
        check("t1 fwd a", {24'd0, a_out}, 32'd7);
        check("t1 fwd b", {24'd0, b_out}, 32'd8);
        drive(8'd0, 1'b0, 8'd0, 1'b0); tick();
        check("t1 valid not yet at t+1", {31'd0, acc_valid}, 32'd0);
        tick();
        check("t1 valid at t+2", {31'd0, acc_valid}, 32'd1);
        check("t1 acc", {16'd0, acc_out}, 32'd100);
        tick(); tick();
        check("t1 held valid", {31'd0, acc_valid}, 32'd1);
        check("t1 held acc", {16'd0, acc_out}, 32'd100);
        acc_ready = 1'b1; tick(); acc_ready = 1'b0;
        check("t1 after handshake", {30'd0, acc_valid, busy}, 32'd0);
        check("t1 acc cleared", {16'd0, acc_out}, 32'd0);

        // ---- Test 2: signed k_len=2, (-3,5)(-128,-128) -> 16369; unsigned -> 17649
        signed_mode = 1'b1; k_len = 8'd2;
        drive(8'hFD, 1'b1, 8'h05, 1'b1); tick();
        signed_mode = 1'b0;                         // ignored mid-tile
        drive(8'h80, 1'b1, 8'h80, 1'b1); tick();
        finish_tile("t2 signed", 32'd16369);
        signed_mode = 1'b0;
        drive(8'hFD, 1'b1, 8'h05, 1'b1); tick();
        drive(8'h80, 1'b1, 8'h80, 1'b1); tick();
        finish_tile("t2 unsigned", 32'd17649);

        // ---- Test 3: k_len=3, valid_b low on alternate cycles -> 20+36+56=112
        t3_a  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
        t3_b  = '{8'd2,  8'd9,  8'd3,  8'd9,  8'd4};
        t3_vb = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        b_hold = 8'd0;
        k_len = 8'd3;
        for (int i = 0; i < 5; i++) begin
            drive(t3_a[i], 1'b1, t3_b[i], t3_vb[i]);
            tick();
            if (i == 0) k_len = 8'd1;               // ignored mid-tile
            if (t3_vb[i]) b_hold = t3_b[i];
            check($sformatf("t3 a_out step %0d", i), {24'd0, a_out}, {24'd0, t3_a[i]});
            check($sformatf("t3 valids step %0d", i), {30'd0, valid_a_out, valid_b_out},
                  {30'd0, 1'b1, t3_vb[i]});
            check($sformatf("t3 b_out step %0d", i), {24'd0, b_out}, {24'd0, b_hold});
        end
        finish_tile("t3", 32'd112);

        // ---- Test 4: k_len=1, DRAIN stalled 5 cycles with pairs arriving
        k_len = 8'd1;
        drive(8'd3, 1'b1, 8'd3, 1'b1); tick();
        drive(8'd0, 1'b0, 8'd0, 1'b0); tick(); tick();
        check("t4 valid", {31'd0, acc_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(8'(i + 20), 1'b1, 8'd1, 1'b1);
            #1;
            check($sformatf("t4 overrun %0d", i), {31'd0, overrun}, 32'd1);
            tick();
            check($sformatf("t4 acc stable %0d", i), {16'd0, acc_out}, 32'd9);
            check($sformatf("t4 fwd %0d", i), {23'd0, valid_a_out, a_out}, {23'd0, 1'b1, 8'(i + 20)});
        end
        drive(8'd0, 1'b0, 8'd0, 1'b0);
        #1;
        check("t4 overrun clear", {31'd0, overrun}, 32'd0);
        acc_ready = 1'b1; tick(); acc_ready = 1'b0;
        check("t4 idle", {31'd0, busy}, 32'd0);
        drive(8'd2, 1'b1, 8'd2, 1'b1); tick();      // back-to-back tile
        finish_tile("t4 next tile", 32'd4);

        // ---- k_len=0 is treated as 1
        k_len = 8'd0;
        drive(8'd9, 1'b1, 8'd9, 1'b1); tick();
        finish_tile("klen0", 32'd81);

        // ---- Test 5: reset mid-ACCUM after 2 of 4 pairs
        k_len = 8'd4;
        drive(8'd1, 1'b1, 8'd1, 1'b1); tick();
        drive(8'd2, 1'b1, 8'd2, 1'b1); tick();
        drive(8'd0, 1'b0, 8'd0, 1'b0);
        reset = 1'b0;
        #1;
        check("t5 async reset outputs",
              {a_out, b_out, valid_a_out, valid_b_out, acc_valid, busy, overrun, sat_flag, 2'b00},
              32'd0);
        check("t5 async reset acc", {16'd0, acc_out}, 32'd0);
        #1;
        reset = 1'b1;
        tick();
        k_len = 8'd2;
        drive(8'd4, 1'b1, 8'd5, 1'b1); tick();
        drive(8'd6, 1'b1, 8'd7, 1'b1); tick();
        finish_tile("t5 fresh tile", 32'd62);

        // ---- Test 6: unsigned (255,255) twice in 16 bits
        k_len = 8'd2;
        drive(8'd255, 1'b1, 8'd255, 1'b1); tick();
        drive(8'd255, 1'b1, 8'd255, 1'b1); tick();
        drive(8'd0, 1'b0, 8'd0, 1'b0); tick(); tick();
`ifdef MAC_PE_SAT_EN
        check("t6 sat acc", {16'd0, acc_out}, 32'h0000FFFF);
        check("t6 sat flag", {31'd0, sat_flag}, 32'd1);
`else
        check("t6 wrap acc", {16'd0, acc_out}, 32'h0000FC02);
        check("t6 sat flag", {31'd0, sat_flag}, 32'd0);
`endif
        acc_ready = 1'b1; tick(); acc_ready = 1'b0;
        check("t6 flag cleared", {30'd0, sat_flag, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
